// File: rtl/nf10_osnt_gen_pkg.sv
// Shared definitions for the OSNT generator TX path: packet FSM encoding,
// lane geometry and the lane-insert helper used by the timestamp inserter.
package nf10_osnt_gen_pkg;

    localparam int LANE_W         = 64;
    localparam int LANES_PER_BEAT = 4;
    localparam int BEAT_W         = LANE_W * LANES_PER_BEAT;
    localparam int BEAT_CNT_W     = 8;

    localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = 8'hFF;

    typedef enum logic [0:0] {
        ST_SOP  = 1'b0,
        ST_BODY = 1'b1
    } pkt_state_e;

    // Overwrite one 64-bit lane; stamp bit 0 lands on bit LANE_W*lane.
    function automatic logic [BEAT_W-1:0] stamp_lane(
        input logic [BEAT_W-1:0] data,
        input logic [1:0]        lane,
        input logic [LANE_W-1:0] stamp
    );
        logic [BEAT_W-1:0] res;
        res = data;
        for (int l = 0; l < LANES_PER_BEAT; l++) begin
            if (lane == l[1:0]) begin
                res[l*LANE_W +: LANE_W] = stamp;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep AXI4-Stream register slice: a beat accepted on s_* appears on m_*
// the next cycle and stays stable until m_tready takes it.
module axis_reg_slice #(
    parameter int DATA_W = 256,
    parameter int STRB_W = 32,
    parameter int USER_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_rst,

    input  logic [DATA_W-1:0] s_tdata,
    input  logic [STRB_W-1:0] s_tstrb,
    input  logic [USER_W-1:0] s_tuser,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,

    output logic [DATA_W-1:0] m_tdata,
    output logic [STRB_W-1:0] m_tstrb,
    output logic [USER_W-1:0] m_tuser,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready
);

    logic [DATA_W-1:0] tdata_q,  tdata_d;
    logic [STRB_W-1:0] tstrb_q,  tstrb_d;
    logic [USER_W-1:0] tuser_q,  tuser_d;
    logic              tlast_q,  tlast_d;
    logic              tvalid_q, tvalid_d;

    // Refill in the same cycle the held beat drains, so no bubble under ready.
    assign s_tready = !tvalid_q || m_tready;

    always_comb begin
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (sw_rst) begin
            tdata_d  = '0;
            tstrb_d  = '0;
            tuser_d  = '0;
            tlast_d  = 1'b0;
            tvalid_d = 1'b0;
        end else if (s_tvalid && s_tready) begin
            tdata_d  = s_tdata;
            tstrb_d  = s_tstrb;
            tuser_d  = s_tuser;
            tlast_d  = s_tlast;
            tvalid_d = 1'b1;
        end else if (m_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tstrb  = tstrb_q;
    assign m_tuser  = tuser_q;
    assign m_tlast  = tlast_q;
    assign m_tvalid = tvalid_q;

endmodule

// File: rtl/tx_timestamp_inserter.sv
// TX timestamp inserter: writes the SOP-time stamp_counter into a chosen
// 64-bit lane of each packet on its way to the MAC, with stamped/missed stats.
module tx_timestamp_inserter
    import nf10_osnt_gen_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    input  logic                              sw_rst,
    input  logic                              ts_en,
    input  logic [7:0]                        ts_pos,
    input  logic [63:0]                       stamp_counter,

    output logic [C_S_AXI_DATA_WIDTH-1:0]     stamped_cnt,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     missed_cnt,
    output logic                              dbg_state
);

    localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = 1;

    // Handshake: a beat moves when valid and ready are both high at the rising
    // edge; valid never waits on ready, and payload holds while valid && !ready.
    logic slice_ready;
    logic accept;

    pkt_state_e state_q, state_d;

    logic [BEAT_CNT_W-1:0]         beat_q, beat_d;
    logic [63:0]                   lat_stamp_q, lat_stamp_d;
    logic                          lat_en_q, lat_en_d;
    logic [7:0]                    lat_pos_q, lat_pos_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] stamped_cnt_q, stamped_cnt_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] missed_cnt_q, missed_cnt_d;

    logic                           is_sop;
    logic                           eff_en;
    logic [7:0]                     eff_pos;
    logic [63:0]                    eff_stamp;
    logic                           hit;
    logic                           miss;
    logic [C_S_AXIS_DATA_WIDTH-1:0] stamped_tdata;

    assign s_axis_tready = axi_aresetn && !sw_rst && slice_ready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= ST_SOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sw_rst) begin
            state_d = ST_SOP;
        end else if (accept) begin
            state_d = s_axis_tlast ? ST_SOP : ST_BODY;
        end
    end

    // The SOP beat uses the live config and counter; later beats the latched copy.
    always_comb begin
        is_sop    = (state_q == ST_SOP);
        eff_en    = is_sop ? ts_en         : lat_en_q;
        eff_pos   = is_sop ? ts_pos        : lat_pos_q;
        eff_stamp = is_sop ? stamp_counter : lat_stamp_q;
        hit       = eff_en && (beat_q == {2'b00, eff_pos[7:2]});
        miss      = eff_en && s_axis_tlast && (beat_q < {2'b00, eff_pos[7:2]});
    end

    assign dbg_state = (state_q == ST_BODY);

    always_comb begin
        stamped_tdata = s_axis_tdata;
        if (hit) begin
            stamped_tdata = stamp_lane(s_axis_tdata, eff_pos[1:0], eff_stamp);
        end
    end

    always_comb begin
        beat_d        = beat_q;
        lat_stamp_d   = lat_stamp_q;
        lat_en_d      = lat_en_q;
        lat_pos_d     = lat_pos_q;
        stamped_cnt_d = stamped_cnt_q;
        missed_cnt_d  = missed_cnt_q;
        if (sw_rst) begin
            beat_d        = '0;
            lat_stamp_d   = '0;
            lat_en_d      = 1'b0;
            lat_pos_d     = '0;
            stamped_cnt_d = '0;
            missed_cnt_d  = '0;
        end else if (accept) begin
            if (is_sop) begin
                lat_stamp_d = stamp_counter;
                lat_en_d    = ts_en;
                lat_pos_d   = ts_pos;
            end
            if (s_axis_tlast) begin
                beat_d = '0;
            end else if (beat_q != BEAT_CNT_MAX) begin
                beat_d = beat_q + 8'd1;
            end
            if (hit) begin
                stamped_cnt_d = stamped_cnt_q + CNT_ONE;
            end
            if (miss) begin
                missed_cnt_d = missed_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            beat_q        <= '0;
            lat_stamp_q   <= '0;
            lat_en_q      <= 1'b0;
            lat_pos_q     <= '0;
            stamped_cnt_q <= '0;
            missed_cnt_q  <= '0;
        end else begin
            beat_q        <= beat_d;
            lat_stamp_q   <= lat_stamp_d;
            lat_en_q      <= lat_en_d;
            lat_pos_q     <= lat_pos_d;
            stamped_cnt_q <= stamped_cnt_d;
            missed_cnt_q  <= missed_cnt_d;
        end
    end

    assign stamped_cnt = stamped_cnt_q;
    assign missed_cnt  = missed_cnt_q;

    axis_reg_slice #(
        .DATA_W (C_S_AXIS_DATA_WIDTH),
        .STRB_W (C_S_AXIS_DATA_WIDTH/8),
        .USER_W (C_S_AXIS_TUSER_WIDTH)
    ) u_out_slice (
        .clk      (axi_aclk),
        .rst_n    (axi_aresetn),
        .sw_rst   (sw_rst),
        .s_tdata  (stamped_tdata),
        .s_tstrb  (s_axis_tstrb),
        .s_tuser  (s_axis_tuser),
        .s_tlast  (s_axis_tlast),
        .s_tvalid (accept),
        .s_tready (slice_ready),
        .m_tdata  (m_axis_tdata),
        .m_tstrb  (m_axis_tstrb),
        .m_tuser  (m_axis_tuser),
        .m_tlast  (m_axis_tlast),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_tx_timestamp_inserter.sv
// Bench for tx_timestamp_inserter: random packets against a packet-level
// stamping model, plus directed packets with hand-computed expectations.
module tb_tx_timestamp_inserter;

    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;
    localparam int CW = 32;
    localparam int BW = DW + SW + UW + 1;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [SW-1:0] s_axis_tstrb = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic          sw_rst = 1'b0;
    logic          ts_en = 1'b0;
    logic [7:0]    ts_pos = '0;
    logic [63:0]   stamp_counter = '0;
    logic [CW-1:0] stamped_cnt;
    logic [CW-1:0] missed_cnt;
    logic          dbg_state;

    always #5 axi_aclk = ~axi_aclk;

    tx_timestamp_inserter dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .sw_rst        (sw_rst),
        .ts_en         (ts_en),
        .ts_pos        (ts_pos),
        .stamp_counter (stamp_counter),
        .stamped_cnt   (stamped_cnt),
        .missed_cnt    (missed_cnt),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    logic [BW-1:0] exp_q[$];
    int            due_q[$];
    int            cnt_due_q[$];
    int            cnt_ds_q[$];
    int            cnt_dm_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] sent_q[$];
    logic [CW-1:0] exp_stamped = '0;
    logic [CW-1:0] exp_missed = '0;
    bit            m_in_pkt = 0;
    bit            m_en = 0;
    logic [7:0]    m_pos = '0;
    logic [63:0]   m_stamp = '0;
    int            m_k = 0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_mis = 0;
    int            retries = 0;
    bit            stamp_inc = 0;

    always @(posedge axi_aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        due_q.delete();
        cnt_due_q.delete();
        cnt_ds_q.delete();
        cnt_dm_q.delete();
        exp_stamped = '0;
        exp_missed  = '0;
        m_in_pkt    = 0;
    endtask

    // Packet-level rule: the stamp taken at the first beat goes into word
    // ts_pos of the packet, if the packet is long enough; otherwise it is a miss.
    task automatic model_accept(input logic [DW-1:0] d, input logic [SW-1:0] s,
                                input logic [UW-1:0] u, input logic l);
        logic [DW-1:0] o;
        int tgt, lane, ds, dm;
        if (!m_in_pkt) begin
            m_in_pkt = 1;
            m_en     = ts_en;
            m_pos    = ts_pos;
            m_stamp  = stamp_counter;
            m_k      = 0;
        end
        o = d;
        tgt = int'(m_pos) / 4;
        lane = int'(m_pos) % 4;
        ds = 0;
        dm = 0;
        if (m_en && m_k == tgt) begin
            o[lane*64 +: 64] = m_stamp;
            ds = 1;
        end
        if (l) begin
            if (m_en && m_k < tgt) dm = 1;
            m_in_pkt = 0;
        end else begin
            m_k++;
        end
        exp_q.push_back({o, s, u, l});
        due_q.push_back(cyc + 1);
        cnt_due_q.push_back(cyc + 1);
        cnt_ds_q.push_back(ds);
        cnt_dm_q.push_back(dm);
    endtask

    // ---------------- compare process ----------------
    always @(negedge axi_aclk) begin
        if (axi_aresetn && !sw_rst) begin
            while (cnt_due_q.size() != 0 && cnt_due_q[0] <= cyc) begin
                exp_stamped = exp_stamped + CW'(cnt_ds_q[0]);
                exp_missed  = exp_missed + CW'(cnt_dm_q[0]);
                void'(cnt_due_q.pop_front());
                void'(cnt_ds_q.pop_front());
                void'(cnt_dm_q.pop_front());
            end
            check("stamped_cnt", stamped_cnt, exp_stamped);
            check("missed_cnt", missed_cnt, exp_missed);
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_tvalid", m_axis_tvalid, 1'b0);
                end else begin
                    check("m_axis_beat", {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast}, exp_q[0]);
                    if (m_axis_tready) begin
                        got_q.push_back(m_axis_tdata);
                        void'(exp_q.pop_front());
                        void'(due_q.pop_front());
                    end
                end
            end else if (exp_q.size() != 0 && due_q[0] <= cyc) begin
                check("late_tvalid", m_axis_tvalid, 1'b1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge axi_aclk);
        #1;
        if (stamp_inc) stamp_counter = stamp_counter + 64'd1;
    endtask

    task automatic send_pkt(input int len, input bit en, input logic [7:0] pos,
                            input int rdy_pct, input int gap_pct,
                            input int abort_at, input bit zero_strb);
        for (int k = 0; k < len; k++) begin
            logic [DW-1:0] d;
            logic [SW-1:0] s;
            logic [UW-1:0] u;
            bit done;
            int tries;
            if (k == abort_at) return;
            for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
            s = zero_strb ? '0 : SW'($urandom);
            u = {$urandom, $urandom, $urandom, $urandom};
            done = 0;
            tries = 0;
            while (!done) begin
                tick();
                m_axis_tready = ($urandom_range(99) < rdy_pct);
                s_axis_tvalid = ($urandom_range(99) >= gap_pct);
                s_axis_tdata  = d;
                s_axis_tstrb  = s;
                s_axis_tuser  = u;
                s_axis_tlast  = (k == len - 1);
                ts_en         = (k == 0) ? en  : 1'($urandom);
                ts_pos        = (k == 0) ? pos : 8'($urandom);
                #1;
                if (s_axis_tvalid && s_axis_tready) begin
                    model_accept(d, s, u, s_axis_tlast);
                    sent_q.push_back(d);
                    done = 1;
                end else begin
                    tries++;
                    retries++;
                    if (tries > 1000) begin
                        check("accept_timeout", s_axis_tready, 1'b1);
                        s_axis_tvalid = 1'b0;
                        return;
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 200) begin
            tick();
            s_axis_tvalid = 1'b0;
            m_axis_tready = 1'b1;
            n++;
        end
        tick();
        tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic clear_logs();
        got_q.delete();
        sent_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        #2;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tready", s_axis_tready, 1'b0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_stamped", stamped_cnt, '0);
        check("rst_missed", missed_cnt, '0);
        check("rst_state", dbg_state, 1'b0);
        @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;

        // Stamping disabled: bit-exact pass-through at one beat per cycle.
        clear_logs();
        retries = 0;
        for (int p = 0; p < 10; p++) send_pkt($urandom_range(1, 6), 0, 8'($urandom), 100, 0, -1, 0);
        check("thru_retries", retries, 0);
        drain();
        check("noen_stamped", stamped_cnt, 32'd0);
        check("noen_missed", missed_cnt, 32'd0);
        check("noen_count", got_q.size(), sent_q.size());
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) check("noen_bitexact", got_q[i], sent_q[i]);

        // Word 0 of a 3-beat packet carries the stamp.
        clear_logs();
        stamp_inc = 0;
        stamp_counter = 64'h1122334455667788;
        send_pkt(3, 1, 8'd0, 100, 0, -1, 0);
        drain();
        check("p0_lane0", got_q[0][63:0], 64'h1122334455667788);
        check("p0_rest", got_q[0][255:64], sent_q[0][255:64]);
        check("p0_beat1", got_q[1], sent_q[1]);
        check("p0_stamped", stamped_cnt, 32'd1);

        // Stamp in beat 1 lane 2 is the SOP-cycle value, not a later one.
        clear_logs();
        stamp_inc = 1;
        stamp_counter = 64'h0FFF;
        send_pkt(4, 1, 8'd6, 100, 0, -1, 0);
        drain();
        check("p6_lane2", got_q[1][191:128], 64'h1000);
        check("p6_other", got_q[1][127:0], sent_q[1][127:0]);
        check("p6_stamped", stamped_cnt, 32'd2);

        // Packet ends before word 12: untouched and counted as missed.
        clear_logs();
        send_pkt(2, 1, 8'd12, 100, 0, -1, 0);
        drain();
        check("p12_b0", got_q[0], sent_q[0]);
        check("p12_b1", got_q[1], sent_q[1]);
        check("p12_missed", missed_cnt, 32'd1);
        check("p12_stamped", stamped_cnt, 32'd2);

        // Target lane with no strobes is still overwritten.
        clear_logs();
        stamp_inc = 0;
        stamp_counter = 64'hDEADBEEF00000001;
        send_pkt(2, 1, 8'd7, 100, 0, -1, 1);
        drain();
        check("strb0_lane3", got_q[1][255:192], 64'hDEADBEEF00000001);
        check("strb0_stamped", stamped_cnt, 32'd3);

        // Random traffic with backpressure and input gaps.
        stamp_inc = 1;
        stamp_counter = {$urandom, $urandom};
        for (int p = 0; p < 100; p++) begin
            int len, pp;
            len = $urandom_range(1, 8);
            pp = $urandom_range(0, len*4 + 7);
            if (pp > 255) pp = 255;
            send_pkt(len, ($urandom_range(3) != 0), 8'(pp), 50, 20, -1, ($urandom_range(9) == 0));
        end
        send_pkt(70, 1, 8'hFF, 50, 10, -1, 0);
        drain();

        // Software reset mid-packet.
        send_pkt(5, 1, 8'd0, 100, 0, 2, 0);
        tick();
        sw_rst = 1'b1;
        s_axis_tvalid = 1'b0;
        model_clear();
        tick();
        sw_rst = 1'b0;
        #1;
        check("swrst_tvalid", m_axis_tvalid, 1'b0);
        check("swrst_stamped", stamped_cnt, 32'd0);
        check("swrst_state", dbg_state, 1'b0);
        clear_logs();
        stamp_inc = 0;
        stamp_counter = 64'hA5A5A5A55A5A5A5A;
        send_pkt(2, 1, 8'd1, 100, 0, -1, 0);
        drain();
        check("swrst_next_lane1", got_q[0][127:64], 64'hA5A5A5A55A5A5A5A);
        check("swrst_next_stamped", stamped_cnt, 32'd1);

        // Asynchronous reset at beat 2 of a 5-beat packet.
        send_pkt(5, 1, 8'd0, 100, 0, 2, 0);
        axi_aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check("arst_tvalid", m_axis_tvalid, 1'b0);
        check("arst_tready", s_axis_tready, 1'b0);
        check("arst_stamped", stamped_cnt, 32'd0);
        check("arst_missed", missed_cnt, 32'd0);
        check("arst_tdata", m_axis_tdata, '0);
        model_clear();
        tick();
        axi_aresetn = 1'b1;
        clear_logs();
        stamp_counter = 64'h0123456789ABCDEF;
        send_pkt(3, 1, 8'd5, 100, 0, -1, 0);
        drain();
        check("arst_next_lane1", got_q[1][127:64], 64'h0123456789ABCDEF);
        check("arst_next_b0", got_q[0], sent_q[0]);
        check("arst_next_stamped", stamped_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
